// File: rtl/vend_controller_if.sv
// Front-panel and actuator signal bundle for the vending controller.
// The panel/dispenser side is the master; the controller is the slave.
interface vend_controller_if;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       disp_ack;
    logic       disp_req;
    logic       disp_item;
    logic       chg_pulse;
    logic       coin_reject;
    logic [2:0] credit;
    logic       busy;

    modport master (
        output coin, sel, disp_ack,
        input  disp_req, disp_item, chg_pulse, coin_reject, credit, busy
    );

    modport slave (
        input  coin, sel, disp_ack,
        output disp_req, disp_item, chg_pulse, coin_reject, credit, busy
    );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, two-item selection,
// dispenser request/ack handshake and nickel-at-a-time change return.
module vend_controller #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int MAX_CREDIT = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    vend_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

    localparam logic [2:0] P0      = 3'(PRICE0);
    localparam logic [2:0] P1      = 3'(PRICE1);
    localparam logic [3:0] MAX_C   = 4'(MAX_CREDIT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] credit_q, credit_d;
    logic [7:0] timer_q, timer_d;
    logic       disp_req_q, disp_req_d;
    logic       disp_item_q, disp_item_d;
    logic       chg_pulse_q, chg_pulse_d;
    logic       coin_reject_q, coin_reject_d;
    logic       busy_q, busy_d;

    logic [3:0] coin_val;
    logic [3:0] coin_sum;
    logic       coin_any;
    logic       coin_ok;
    logic [2:0] price;
    logic       sel_ok;
    logic       cancel_ok;

    // Decode the panel inputs against the current credit.
    always_comb begin
        coin_val = 4'd0;
        if (bus.coin == 2'b01) coin_val = 4'd1;
        if (bus.coin == 2'b10) coin_val = 4'd2;
        coin_any  = (bus.coin != 2'b00);
        coin_sum  = {1'b0, credit_q} + coin_val;
        coin_ok   = (coin_val != 4'd0) && (coin_sum <= MAX_C);
        price     = bus.sel[1] ? P1 : P0;
        sel_ok    = (bus.sel == 2'b01 || bus.sel == 2'b10)
                    && (credit_q >= price);
        cancel_ok = (bus.sel == 2'b11) && (credit_q != 3'd0);
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = timer_q;
        disp_req_d    = disp_req_q;
        disp_item_d   = disp_item_q;
        chg_pulse_d   = 1'b0;
        coin_reject_d = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (sel_ok) begin
                    // A valid selection wins over any coin offered with it.
                    state_d       = DISPENSE;
                    credit_d      = credit_q - price;
                    disp_req_d    = 1'b1;
                    disp_item_d   = bus.sel[1];
                    timer_d       = 8'd0;
                    coin_reject_d = coin_any;
                end else if (cancel_ok) begin
                    state_d       = CHANGE;
                    timer_d       = 8'd0;
                    coin_reject_d = coin_any;
                end else begin
                    if (coin_any) begin
                        if (coin_ok) begin
                            credit_d = coin_sum[2:0];
                            state_d  = COLLECT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (state_q == COLLECT) begin
                        if (coin_any || bus.sel != 2'b00) begin
                            timer_d = 8'd0;
                        end else if (timer_q == TO_LAST) begin
                            state_d = CHANGE;
                            timer_d = 8'd0;
                        end else begin
                            timer_d = timer_q + 8'd1;
                        end
                    end else begin
                        timer_d = 8'd0;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_any;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    state_d    = (credit_q != 3'd0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_any;
                if (chg_pulse_q) begin
                    // Low half of the last pulse is spent back in IDLE.
                    if (credit_q == 3'd0) state_d = IDLE;
                end else if (credit_q != 3'd0) begin
                    chg_pulse_d = 1'b1;
                    credit_d    = credit_q - 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    // State and registered outputs; reset abandons any credit held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= 3'd0;
            timer_q       <= 8'd0;
            disp_req_q    <= 1'b0;
            disp_item_q   <= 1'b0;
            chg_pulse_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            disp_req_q    <= disp_req_d;
            disp_item_q   <= disp_item_d;
            chg_pulse_q   <= chg_pulse_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_item   = disp_item_q;
    assign bus.chg_pulse   = chg_pulse_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_vend_controller;
    typedef struct {
        logic [1:0] coin;
        logic [1:0] sel;
        logic       ack;
        logic [2:0] credit;
        logic       req;
        logic       item;
        logic       chg;
        logic       rej;
        logic       busy;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    vec_t tbl[$];

    vend_controller_if vif ();

    vend_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [1:0] c, input logic [1:0] s, input logic a,
        input logic [2:0] cr, input logic rq, input logic it,
        input logic cp, input logic rj, input logic by
    );
        vec_t v;
        v.coin = c; v.sel = s; v.ack = a;
        v.credit = cr; v.req = rq; v.item = it;
        v.chg = cp; v.rej = rj; v.busy = by;
        return v;
    endfunction

    function automatic logic [7:0] obs();
        logic it;
        it = vif.disp_req ? vif.disp_item : 1'b0;
        return {vif.credit, vif.disp_req, it,
                vif.chg_pulse, vif.coin_reject, vif.busy};
    endfunction

    function automatic logic [7:0] expv(input vec_t v);
        logic it;
        it = v.req ? v.item : 1'b0;
        return {v.credit, v.req, it, v.chg, v.rej, v.busy};
    endfunction

    task automatic chk(input string name,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            passed++;
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge.
    task automatic cyc(input logic [1:0] c, input logic [1:0] s,
                       input logic a);
        @(negedge clk);
        vif.coin = c;
        vif.sel = s;
        vif.disp_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_busy;
        logic saw_chg;
        total = 0;
        passed = 0;
        vif.coin = 2'b00;
        vif.sel = 2'b00;
        vif.disp_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", obs(), 8'b0);
        @(negedge clk);
        rst = 1'b0;

        // coin, sel, ack | credit, req, item, chg, rej, busy
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 6, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 2, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(2, 0, 0, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 2, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].coin, tbl[i].sel, tbl[i].ack);
            chk($sformatf("vec%0d", i), obs(), expv(tbl[i]));
        end

        // Timeout: an invalid coin at TIMEOUT-1 restarts the count.
        cyc(1, 0, 0);
        chk("to_nickel", obs(), {3'd1, 5'b00000});
        saw_busy = 1'b0;
        for (int k = 0; k < 254; k++) begin
            cyc(0, 0, 0);
            saw_busy |= vif.busy;
        end
        chk("to_no_early1", {7'd0, saw_busy}, 8'd0);
        cyc(3, 0, 0);
        chk("to_restart", obs(), {3'd1, 5'b00010});
        saw_busy = 1'b0;
        for (int k = 0; k < 254; k++) begin
            cyc(0, 0, 0);
            saw_busy |= vif.busy;
        end
        chk("to_no_early2", {7'd0, saw_busy}, 8'd0);
        cyc(0, 0, 0);
        chk("to_enter_chg", obs(), {3'd1, 5'b00001});
        cyc(0, 0, 0);
        chk("to_pulse", obs(), {3'd0, 5'b00101});
        cyc(0, 0, 0);
        chk("to_idle", obs(), 8'd0);

        // Asynchronous reset while a request is outstanding.
        cyc(2, 0, 0);
        cyc(2, 0, 0);
        cyc(2, 0, 0);
        cyc(0, 2, 0);
        chk("rst_pre", obs(), {3'd2, 5'b11001});
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {vif.credit, vif.disp_req, 3'b000, vif.busy},
            8'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_chg = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0);
            saw_chg |= vif.chg_pulse | vif.busy | (vif.credit != 3'd0);
        end
        chk("rst_no_change", {7'd0, saw_chg}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller for the coin-operated vending datapath. It accumulates coin credit, matches a product selection against per-item prices, and drives a request/acknowledge handshake to the dispenser mechanism. It then returns any change one nickel at a time. It sits between the coin/selection front panel and the dispenser/change-return actuators, replacing fixed single-price sequencing with a multi-item, refund-capable scheduler.

## Interface
Parameters:
- PRICE0, default 3: price of item 0, in nickels (5-cent units).
- PRICE1, default 4: price of item 1, in nickels.
- MAX_CREDIT, default 6: maximum credit held, in nickels; must be ≤ 7.
- TIMEOUT, default 255: idle cycles in COLLECT before an automatic refund; range 1–255.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- coin  in  2  coin sampled each cycle: 00 none, 01 nickel (+1), 10 dime (+2), 11 invalid.
- sel  in  2  selection: 00 none, 01 item 0, 10 item 1, 11 cancel.
- disp_ack  in  1  dispenser acknowledge, level-sampled.
- disp_req  out  1  dispense request.
- disp_item  out  1  item being dispensed (0 or 1); valid while disp_req is high.
- chg_pulse  out  1  one-cycle pulse; each pulse returns one nickel.
- coin_reject  out  1  one-cycle pulse; the coin offered on the previous cycle was rejected.
- credit  out  3  current credit, in nickels.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE. Reset puts the block in IDLE and clears credit, the timer and every output.
- IDLE/COLLECT, coin handling:
  - A valid coin with credit+value ≤ MAX_CREDIT adds its value to credit and moves the block to COLLECT.
  - A coin that would exceed MAX_CREDIT, or coin=11, is rejected: coin_reject pulses and credit is unchanged.
- IDLE/COLLECT, selection handling:
  - sel=01 or 10 with credit ≥ price: go to DISPENSE, set credit to credit−price, latch disp_item.
  - sel=01 or 10 with credit < price: ignored, no state change. The cycle still counts as activity for the timer.
  - sel=11 with credit > 0: go to CHANGE. sel=11 with credit 0: ignored.
- Simultaneous coin and valid selection or cancel: the selection wins and the coin is rejected. A coin arriving together with an ignored selection is processed normally.
- Timer:
  - Counts in COLLECT on cycles with coin=00 and sel=00.
  - Resets to 0 on any coin or sel activity, and on entry to COLLECT.
  - On reaching TIMEOUT, the block goes to CHANGE.
- DISPENSE:
  - disp_req and disp_item are held stable until disp_ack is sampled high.
  - On that edge, disp_req drops and the block goes to CHANGE if credit > 0, otherwise to IDLE.
  - There is no timeout; the block waits on disp_ack indefinitely.
- CHANGE:
  - If chg_pulse=0 and credit > 0: the next edge sets chg_pulse=1 and decrements credit.
  - If chg_pulse=1: the next edge clears chg_pulse.
  - If chg_pulse=0 and credit=0: go to IDLE.
  - Pulses therefore alternate one cycle high, one cycle low.
- Coins offered in DISPENSE or CHANGE are rejected. Selections there are ignored.
- Arithmetic: credit is 3-bit unsigned and can never overflow or underflow, by construction of the rules above.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Coin accepted at edge N: credit shows the new value after edge N. A rejected coin drives coin_reject high for exactly the one cycle after edge N.
- Selection sampled at edge N: disp_req high after edge N, with credit already reduced.
- disp_ack sampled high at edge M: disp_req is low after edge M. A disp_ack that is high on the first request cycle completes the handshake on that same edge.
- Change of k nickels: first chg_pulse one cycle after entering CHANGE; 2k cycles from entering CHANGE until IDLE.
- Asynchronous rst mid-transaction: immediate return to IDLE, outputs forced to 0, credit lost. No change is paid.

## Test plan
- Nickel, then dime, then sel=01 → credit 1, then 3; disp_req=1 with disp_item=0 and credit 0; ack after 4 cycles → disp_req drops, IDLE, no chg_pulse.
- Dime, dime, sel=01 → dispense item 0; after ack, one chg_pulse; credit 1→0; IDLE.
- Three dimes (credit 6), then nickel → coin_reject for 1 cycle, credit stays 6; coin=11 → coin_reject, credit 6.
- Dime, sel=10 (price 4) → ignored, credit 2; sel=11 → two chg_pulses in alternating cycles, then IDLE.
- Nickel, then TIMEOUT idle cycles → CHANGE, one chg_pulse, IDLE; a coin at TIMEOUT−1 restarts the count.
- rst asserted while disp_req=1 and credit 2 → disp_req, credit and busy go to 0 immediately; no chg_pulse after release.
